// File: rtl/hazard_scoreboard_pkg.sv
// Shared widths and instruction-class encodings for the hazard scoreboard slice.
package hazard_scoreboard_pkg;

  localparam int REG_IDX_W = 5;
  localparam int SB_CNT_W  = 4;

  typedef enum logic [1:0] {
    CLS_OTHER = 2'd0,
    CLS_LOAD  = 2'd1,
    CLS_MDU   = 2'd2
  } instr_cls_e;

  // Load wins if both flags are raised; that combination is illegal upstream anyway.
  function automatic instr_cls_e instr_class(input logic is_load, input logic is_mdu);
    instr_cls_e cls;
    if (is_load) begin
      cls = CLS_LOAD;
    end else if (is_mdu) begin
      cls = CLS_MDU;
    end else begin
      cls = CLS_OTHER;
    end
    return cls;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// One scoreboard slot: loadable countdown that stops at zero, plus a nonzero flag.
module sb_entry
  import hazard_scoreboard_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                load_i,
  input  logic [SB_CNT_W-1:0] load_val_i,
  output logic                nz_o
);

  logic [SB_CNT_W-1:0] cnt_r;
  logic [SB_CNT_W-1:0] cnt_nxt_s;

  // A load takes precedence over the per-cycle decrement.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (load_i) begin
      cnt_nxt_s = load_val_i;
    end else if (cnt_r != {SB_CNT_W{1'b0}}) begin
      cnt_nxt_s = cnt_r - SB_CNT_W'(1);
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Counter state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_r <= {SB_CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  assign nz_o = (cnt_r != {SB_CNT_W{1'b0}});

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-side hazard unit: countdown scoreboard for load/MDU writes, MDU occupancy,
// redirect-first pipeline controls and a saturating stall-cycle counter.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREG     = 32,
  parameter int LOAD_LAT = 1,
  parameter int MDU_LAT  = 8,
  parameter int CNT_W    = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 D_valid_i,
  input  logic [REG_IDX_W-1:0] D_rs1_i,
  input  logic [REG_IDX_W-1:0] D_rs2_i,
  input  logic                 D_use_rs1_i,
  input  logic                 D_use_rs2_i,
  input  logic [REG_IDX_W-1:0] D_rd_i,
  input  logic                 D_need_rd_i,
  input  logic                 D_is_load_i,
  input  logic                 D_is_mdu_i,
  input  logic                 E_redirect_i,
  output logic                 PC_stall_o,
  output logic                 F_stall_o,
  output logic                 F_bubble_o,
  output logic                 D_bubble_o,
  output logic                 E_bubble_o,
  output logic                 issue_o,
  output logic                 mdu_busy_o,
  output logic [CNT_W-1:0]     stall_cnt_o
);

  localparam int NIDX = 2 ** REG_IDX_W;
  localparam logic [SB_CNT_W-1:0] LOAD_VAL = SB_CNT_W'(LOAD_LAT);
  localparam logic [SB_CNT_W-1:0] MDU_VAL  = SB_CNT_W'(MDU_LAT);

  logic                active_r;
  logic [NIDX-1:0]     pend_nz_s;
  logic                mdu_nz_s;
  logic                raw1_s, raw2_s, waw_s, struct_s, hz_s;
  logic                wr_en_s;
  instr_cls_e          cls_s;
  logic [SB_CNT_W-1:0] set_val_s;
  logic [CNT_W-1:0]    stall_cnt_r;

  // Holds every control low until the first edge after reset release.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      active_r <= 1'b0;
    end else begin
      active_r <= 1'b1;
    end
  end

  assign raw1_s   = D_use_rs1_i & (D_rs1_i != REG_IDX_W'(0)) & pend_nz_s[D_rs1_i];
  assign raw2_s   = D_use_rs2_i & (D_rs2_i != REG_IDX_W'(0)) & pend_nz_s[D_rs2_i];
  assign waw_s    = D_need_rd_i & (D_rd_i != REG_IDX_W'(0)) & pend_nz_s[D_rd_i];
  assign struct_s = D_is_mdu_i & mdu_nz_s;
  assign hz_s     = active_r & D_valid_i & (raw1_s | raw2_s | waw_s | struct_s);

  // Pipeline controls: redirect beats hazard, hazard beats issue.
  always_comb begin
    PC_stall_o = 1'b0;
    F_stall_o  = 1'b0;
    F_bubble_o = 1'b0;
    D_bubble_o = 1'b0;
    issue_o    = 1'b0;
    if (!active_r) begin
      issue_o = 1'b0;
    end else if (E_redirect_i) begin
      F_bubble_o = 1'b1;
      D_bubble_o = 1'b1;
    end else if (hz_s) begin
      PC_stall_o = 1'b1;
      F_stall_o  = 1'b1;
      D_bubble_o = 1'b1;
    end else begin
      issue_o = D_valid_i;
    end
  end

  // Select the countdown value for the issuing instruction's destination.
  always_comb begin
    cls_s     = instr_class(D_is_load_i, D_is_mdu_i);
    set_val_s = {SB_CNT_W{1'b0}};
    wr_en_s   = 1'b0;
    case (cls_s)
      CLS_LOAD: begin
        set_val_s = LOAD_VAL;
        wr_en_s   = issue_o & D_need_rd_i & (D_rd_i != REG_IDX_W'(0));
      end
      CLS_MDU: begin
        set_val_s = MDU_VAL;
        wr_en_s   = issue_o & D_need_rd_i & (D_rd_i != REG_IDX_W'(0));
      end
      default: begin
        set_val_s = {SB_CNT_W{1'b0}};
        wr_en_s   = 1'b0;
      end
    endcase
  end

  // Slots outside 1..NREG-1 read as never pending, so any 5-bit index is safe.
  for (genvar r = 0; r < NIDX; r++) begin : g_pend
    if (r >= 1 && r < NREG) begin : g_ent
      sb_entry u_ent (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .load_i     (wr_en_s & (D_rd_i == REG_IDX_W'(r))),
        .load_val_i (set_val_s),
        .nz_o       (pend_nz_s[r])
      );
    end else begin : g_none
      assign pend_nz_s[r] = 1'b0;
    end
  end

  sb_entry u_mdu (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .load_i     (issue_o & D_is_mdu_i),
    .load_val_i (MDU_VAL),
    .nz_o       (mdu_nz_s)
  );

  // Saturating count of cycles lost to data or structural hazards.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (hz_s & ~E_redirect_i & ~(&stall_cnt_r)) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign E_bubble_o  = 1'b0;
  assign mdu_busy_o  = mdu_nz_s;
  assign stall_cnt_o = stall_cnt_r;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed and randomized check of hazard_scoreboard against a behavioural model.
module tb_hazard_scoreboard;

  localparam int LL = 1;
  localparam int ML = 8;
  localparam int CW = 6;
  localparam longint SAT = (longint'(1) << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic D_valid, D_use_rs1, D_use_rs2, D_need_rd, D_is_load, D_is_mdu, E_redirect;
  logic [4:0] D_rs1, D_rs2, D_rd;
  logic PC_stall, F_stall, F_bubble, D_bubble, E_bubble, issue, mdu_busy;
  logic [CW-1:0] stall_cnt;

  hazard_scoreboard #(.NREG(32), .LOAD_LAT(LL), .MDU_LAT(ML), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .D_valid_i(D_valid), .D_rs1_i(D_rs1), .D_rs2_i(D_rs2),
    .D_use_rs1_i(D_use_rs1), .D_use_rs2_i(D_use_rs2), .D_rd_i(D_rd), .D_need_rd_i(D_need_rd),
    .D_is_load_i(D_is_load), .D_is_mdu_i(D_is_mdu), .E_redirect_i(E_redirect),
    .PC_stall_o(PC_stall), .F_stall_o(F_stall), .F_bubble_o(F_bubble), .D_bubble_o(D_bubble),
    .E_bubble_o(E_bubble), .issue_o(issue), .mdu_busy_o(mdu_busy), .stall_cnt_o(stall_cnt)
  );

  always #5 clk = ~clk;

  int     pend_m[32];
  int     mdu_m = 0;
  longint stall_m = 0;
  bit     active_m = 1'b0;
  bit     e_pcs, e_fs, e_fb, e_db, e_iss, e_hz;
  int     n_checks = 0;
  int     n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected controls from the current model state and decode inputs.
  task automatic eval_model();
    bit hz;
    hz = D_valid && ((D_use_rs1 && D_rs1 != 0 && pend_m[D_rs1] > 0) ||
                     (D_use_rs2 && D_rs2 != 0 && pend_m[D_rs2] > 0) ||
                     (D_need_rd && D_rd != 0 && pend_m[D_rd] > 0) ||
                     (D_is_mdu && mdu_m > 0));
    {e_pcs, e_fs, e_fb, e_db, e_iss, e_hz} = 6'b0;
    if (active_m && rst_n) begin
      e_hz = hz;
      if (E_redirect) begin
        e_fb = 1'b1; e_db = 1'b1;
      end else if (hz) begin
        e_pcs = 1'b1; e_fs = 1'b1; e_db = 1'b1;
      end else begin
        e_iss = D_valid;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (pend_m[i]) pend_m[i] = 0;
      mdu_m = 0; stall_m = 0; active_m = 1'b0;
    end else begin
      eval_model();
      if (active_m) begin
        if (e_hz && !E_redirect && stall_m < SAT) stall_m++;
        foreach (pend_m[i]) if (pend_m[i] > 0) pend_m[i]--;
        if (e_iss && D_need_rd && D_rd != 0) begin
          if (D_is_load) pend_m[D_rd] = LL;
          else if (D_is_mdu) pend_m[D_rd] = ML;
        end
        if (e_iss && D_is_mdu) mdu_m = ML;
        else if (mdu_m > 0) mdu_m--;
      end
      active_m = 1'b1;
    end
  end

  always @(negedge clk) begin
    eval_model();
    chk("PC_stall", PC_stall, e_pcs);
    chk("F_stall", F_stall, e_fs);
    chk("F_bubble", F_bubble, e_fb);
    chk("D_bubble", D_bubble, e_db);
    chk("E_bubble", E_bubble, 0);
    chk("issue", issue, e_iss);
    chk("mdu_busy", mdu_busy, mdu_m > 0);
    chk("stall_cnt", stall_cnt, stall_m);
  end

  task automatic drv(input bit v, input bit [4:0] r1, input bit u1, input bit [4:0] r2,
                     input bit u2, input bit [4:0] rd, input bit nd, input bit ld,
                     input bit md, input bit rdr);
    D_valid = v; D_rs1 = r1; D_use_rs1 = u1; D_rs2 = r2; D_use_rs2 = u2;
    D_rd = rd; D_need_rd = nd; D_is_load = ld; D_is_mdu = md; E_redirect = rdr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_issue", issue, 0);
    chk("rst_pc_stall", PC_stall, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    rst_n = 1'b1;
    drv(1, 5, 1, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("first_f_bubble", F_bubble, 0);
    chk("first_issue", issue, 0);
    tick();

    // load x5 then dependent add: one bubble
    drv(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
    @(negedge clk); chk("ld_issue", issue, 1); tick();
    drv(1, 5, 1, 0, 0, 6, 1, 0, 0, 0);
    @(negedge clk);
    chk("lu_pc_stall", PC_stall, 1); chk("lu_f_stall", F_stall, 1);
    chk("lu_d_bubble", D_bubble, 1); chk("lu_issue", issue, 0);
    tick();
    @(negedge clk); chk("lu_issue_after", issue, 1); chk("lu_cnt", stall_cnt, 1); tick();

    // MDU writes x7, consumer reads x7
    drv(1, 1, 1, 2, 1, 7, 1, 0, 1, 0);
    @(negedge clk); chk("mdu_issue", issue, 1); tick();
    drv(1, 7, 1, 0, 0, 8, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); chk("mdu_raw_stall", PC_stall, 1); chk("mdu_busy_hi", mdu_busy, 1); tick();
    end
    @(negedge clk);
    chk("mdu_raw_issue", issue, 1); chk("mdu_busy_lo", mdu_busy, 0); chk("mdu_cnt", stall_cnt, 9);
    tick();

    // back-to-back MDU ops, independent registers: structural stall
    drv(1, 0, 0, 0, 0, 1, 1, 0, 1, 0);
    @(negedge clk); chk("mdu1_issue", issue, 1); tick();
    drv(1, 3, 1, 4, 1, 2, 1, 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); chk("struct_stall", D_bubble, 1); chk("struct_no_issue", issue, 0); tick();
    end
    @(negedge clk);
    chk("mdu2_issue", issue, 1); chk("mdu2_busy_lo", mdu_busy, 0); chk("struct_cnt", stall_cnt, 17);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (10) tick();

    // redirect wins over a load-use hazard; pend[x3] keeps draining
    drv(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
    @(negedge clk); chk("ld3_issue", issue, 1); tick();
    drv(1, 3, 1, 0, 0, 9, 1, 0, 0, 1);
    @(negedge clk);
    chk("rdr_f_bubble", F_bubble, 1); chk("rdr_d_bubble", D_bubble, 1);
    chk("rdr_pc_stall", PC_stall, 0); chk("rdr_issue", issue, 0);
    tick();
    drv(1, 3, 1, 0, 0, 9, 1, 0, 0, 0);
    @(negedge clk); chk("post_rdr_issue", issue, 1); chk("rdr_cnt", stall_cnt, 17); tick();

    // x0 is never tracked
    drv(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    @(negedge clk); chk("ld_x0_issue", issue, 1); tick();
    drv(1, 0, 1, 0, 1, 0, 1, 0, 0, 0);
    @(negedge clk); chk("x0_use_issue", issue, 1); chk("x0_no_stall", PC_stall, 0); tick();

    // reset during the 4th cycle of an MDU stall
    drv(1, 0, 0, 0, 0, 7, 1, 0, 1, 0);
    tick();
    drv(1, 7, 1, 0, 0, 10, 1, 0, 0, 0);
    repeat (3) begin
      @(negedge clk); chk("pre_rst_stall", PC_stall, 1); tick();
    end
    @(negedge clk);
    chk("stall4", PC_stall, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_pc_stall", PC_stall, 0); chk("async_f_stall", F_stall, 0);
    chk("async_d_bubble", D_bubble, 0); chk("async_issue", issue, 0);
    chk("async_busy", mdu_busy, 0); chk("async_cnt", stall_cnt, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); chk("rel_first_issue", issue, 0); tick();
    @(negedge clk);
    chk("rel_issue", issue, 1); chk("rel_no_stall", PC_stall, 0); chk("rel_cnt", stall_cnt, 0);
    tick();

    // randomized traffic; load and MDU flags stay exclusive
    for (int n = 0; n < 1500; n++) begin
      int cls;
      cls = int'($urandom_range(0, 3));
      drv(($urandom % 8) != 0, 5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)),
          1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom), cls == 0, cls == 1,
          ($urandom % 10) == 0);
      tick();
    end
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
